// File: rtl/trap_csr.sv
`default_nettype none
// ============================================================================
// Module      : trap_csr
// Description : Machine-mode CSR file. Captures trap state (mepc, mcause,
//               mtval) and stacks mstatus.MIE/MPIE when the Control Unit
//               inserts a trap, and unstacks them on an MRET pseudo trap.
//               Returns mepc, mtvec and the enabled pending interrupts to the
//               trap unit, serves Zicsr accesses from the Execute Stage, and
//               implements the 64-bit mcycle/minstret counters.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n          core clock, synchronous active-low reset
//   csr_en_i            CSR instruction valid in Execute (not a bubble)
//   csr_op_i            00 read, 01 write, 10 set bits, 11 clear bits
//   csr_addr_i          CSR address
//   csr_wdata_i         rs1 value or zero-extended uimm
//   csr_rdata_o         old value of the addressed CSR (combinational)
//   csr_illegal_o       unimplemented CSR or write to a read-only CSR
//   trap_insert_i       trap inserted this cycle
//   trap_is_mret_i      the inserted trap is an MRET
//   trap_epc_i/cause_i/val_i  values recorded on a real trap
//   irq_soft_i/timer_i/ext_i  machine interrupt request lines
//   inst_retire_i       one instruction retired this cycle
//   interrupts_o        mip & mie, zero while mstatus.MIE is clear
//   mepc_o, mtvec_o     current mepc and mtvec
// ============================================================================
module trap_csr #(
  parameter int          HART_ID     = 0,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_en_i,
  input  logic [1:0]  csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        trap_insert_i,
  input  logic        trap_is_mret_i,
  input  logic [31:0] trap_epc_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] trap_val_i,
  input  logic        irq_soft_i,
  input  logic        irq_timer_i,
  input  logic        irq_ext_i,
  input  logic        inst_retire_i,
  output logic [31:0] interrupts_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mtvec_o
);

  localparam logic [11:0] c_MSTATUS   = 12'h300;
  localparam logic [11:0] c_MISA      = 12'h301;
  localparam logic [11:0] c_MIE       = 12'h304;
  localparam logic [11:0] c_MTVEC     = 12'h305;
  localparam logic [11:0] c_MSCRATCH  = 12'h340;
  localparam logic [11:0] c_MEPC      = 12'h341;
  localparam logic [11:0] c_MCAUSE    = 12'h342;
  localparam logic [11:0] c_MTVAL     = 12'h343;
  localparam logic [11:0] c_MIP       = 12'h344;
  localparam logic [11:0] c_MCYCLE    = 12'hB00;
  localparam logic [11:0] c_MINSTRET  = 12'hB02;
  localparam logic [11:0] c_MCYCLEH   = 12'hB80;
  localparam logic [11:0] c_MINSTRETH = 12'hB82;
  localparam logic [11:0] c_MHARTID   = 12'hF14;

  localparam logic [31:0] c_MISA_VAL  = 32'h4000_0100;  // MXL=1, I extension
  localparam logic [31:0] c_HART_VAL  = 32'(HART_ID);

  // Interrupt-related registers keep only bits 3/7/11, packed as {11,7,3}.
  function automatic logic [31:0] spread_irq(input logic [2:0] v);
    logic [31:0] r;
    r     = '0;
    r[3]  = v[0];
    r[7]  = v[1];
    r[11] = v[2];
    return r;
  endfunction

  // State
  logic        mstatus_mie_q,  mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [2:0]  mie_q,          mie_d;
  logic [2:0]  mip_q;
  logic [31:0] mtvec_q,        mtvec_d;
  logic [31:0] mscratch_q,     mscratch_d;
  logic [31:0] mepc_q,         mepc_d;
  logic [31:0] mcause_q,       mcause_d;
  logic [31:0] mtval_q,        mtval_d;
  logic [63:0] mcycle_q,       mcycle_d;
  logic [63:0] minstret_q,     minstret_d;

  logic [31:0] w_mstatus_rd;
  logic [31:0] w_mtvec_rd;
  logic [31:0] w_rdata;
  logic        w_implemented;
  logic        w_illegal;
  logic        w_csr_we;
  logic [31:0] w_wval;
  logic [1:0]  w_mtvec_mode;

  // MPP is hardwired to machine mode (bits 12:11).
  assign w_mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
  assign w_mtvec_rd   = VECTORED_EN ? mtvec_q : {mtvec_q[31:2], 2'b00};

  // Read mux; also tells whether the address is implemented at all.
  always_comb begin
    w_rdata       = '0;
    w_implemented = 1'b1;
    case (csr_addr_i)
      c_MSTATUS:   w_rdata = w_mstatus_rd;
      c_MISA:      w_rdata = c_MISA_VAL;
      c_MIE:       w_rdata = spread_irq(mie_q);
      c_MTVEC:     w_rdata = w_mtvec_rd;
      c_MSCRATCH:  w_rdata = mscratch_q;
      c_MEPC:      w_rdata = mepc_q;
      c_MCAUSE:    w_rdata = mcause_q;
      c_MTVAL:     w_rdata = mtval_q;
      c_MIP:       w_rdata = spread_irq(mip_q);
      c_MCYCLE:    w_rdata = mcycle_q[31:0];
      c_MCYCLEH:   w_rdata = mcycle_q[63:32];
      c_MINSTRET:  w_rdata = minstret_q[31:0];
      c_MINSTRETH: w_rdata = minstret_q[63:32];
      c_MHARTID:   w_rdata = c_HART_VAL;
      default: begin
        w_rdata       = '0;
        w_implemented = 1'b0;
      end
    endcase
  end

  // Address space 11xx is read-only: any op other than plain read faults.
  assign w_illegal = csr_en_i &
                     (~w_implemented | ((csr_addr_i[11:10] == 2'b11) & (csr_op_i != 2'b00)));

  // A trap in the same cycle takes priority and drops the CSR write.
  assign w_csr_we = csr_en_i & ~w_illegal & ~trap_insert_i & (csr_op_i != 2'b00);

  always_comb begin
    case (csr_op_i)
      2'b01:   w_wval = csr_wdata_i;
      2'b10:   w_wval = w_rdata | csr_wdata_i;
      2'b11:   w_wval = w_rdata & ~csr_wdata_i;
      default: w_wval = w_rdata;
    endcase
  end

  // Reserved MODE encodings (1x) leave the current MODE in place.
  always_comb begin
    if (!VECTORED_EN)
      w_mtvec_mode = 2'b00;
    else if (w_wval[1])
      w_mtvec_mode = mtvec_q[1:0];
    else
      w_mtvec_mode = w_wval[1:0];
  end

  // Next-state logic
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    mcycle_d       = mcycle_q + 64'd1;
    minstret_d     = minstret_q + {63'd0, inst_retire_i};

    if (trap_insert_i) begin
      if (trap_is_mret_i) begin
        mstatus_mie_d  = mstatus_mpie_q;
        mstatus_mpie_d = 1'b1;
      end else begin
        mepc_d         = {trap_epc_i[31:2], 2'b00};
        mcause_d       = trap_cause_i;
        mtval_d        = trap_val_i;
        mstatus_mpie_d = mstatus_mie_q;
        mstatus_mie_d  = 1'b0;
      end
    end else if (w_csr_we) begin
      // A write to either counter half replaces that half and suppresses
      // the increment of that counter for this cycle.
      case (csr_addr_i)
        c_MSTATUS: begin
          mstatus_mie_d  = w_wval[3];
          mstatus_mpie_d = w_wval[7];
        end
        c_MIE:       mie_d      = {w_wval[11], w_wval[7], w_wval[3]};
        c_MTVEC:     mtvec_d    = {w_wval[31:2], w_mtvec_mode};
        c_MSCRATCH:  mscratch_d = w_wval;
        c_MEPC:      mepc_d     = {w_wval[31:2], 2'b00};
        c_MCAUSE:    mcause_d   = w_wval;
        c_MTVAL:     mtval_d    = w_wval;
        c_MCYCLE:    mcycle_d   = {mcycle_q[63:32], w_wval};
        c_MCYCLEH:   mcycle_d   = {w_wval, mcycle_q[31:0]};
        c_MINSTRET:  minstret_d = {minstret_q[63:32], w_wval};
        c_MINSTRETH: minstret_d = {w_wval, minstret_q[31:0]};
        default: ;  // misa, mip: writes ignored
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mip_q          <= '0;
      mtvec_q        <= MTVEC_RESET;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      mcycle_q       <= '0;
      minstret_q     <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mip_q          <= {irq_ext_i, irq_timer_i, irq_soft_i};
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
    end
  end

  assign csr_rdata_o   = w_rdata;
  assign csr_illegal_o = w_illegal;
  assign interrupts_o  = mstatus_mie_q ? spread_irq(mip_q & mie_q) : 32'h0;
  assign mepc_o        = mepc_q;
  assign mtvec_o       = w_mtvec_rd;

endmodule
`default_nettype wire

// File: tb/tb_trap_csr.sv
`default_nettype none
// ============================================================================
// Module      : tb_trap_csr
// Description : Directed self-checking bench for trap_csr.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trap_csr;

  localparam int HART = 3;

  logic        clk;
  logic        rst_n;
  logic        csr_en;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        trap_insert;
  logic        trap_is_mret;
  logic [31:0] trap_epc;
  logic [31:0] trap_cause;
  logic [31:0] trap_val;
  logic        irq_soft;
  logic        irq_timer;
  logic        irq_ext;
  logic        inst_retire;
  logic [31:0] interrupts;
  logic [31:0] mepc;
  logic [31:0] mtvec;

  int checks;
  int errors;

  trap_csr #(
    .HART_ID     (HART),
    .MTVEC_RESET (32'h0000_0000),
    .VECTORED_EN (1'b1)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .csr_en_i       (csr_en),
    .csr_op_i       (csr_op),
    .csr_addr_i     (csr_addr),
    .csr_wdata_i    (csr_wdata),
    .csr_rdata_o    (csr_rdata),
    .csr_illegal_o  (csr_illegal),
    .trap_insert_i  (trap_insert),
    .trap_is_mret_i (trap_is_mret),
    .trap_epc_i     (trap_epc),
    .trap_cause_i   (trap_cause),
    .trap_val_i     (trap_val),
    .irq_soft_i     (irq_soft),
    .irq_timer_i    (irq_timer),
    .irq_ext_i      (irq_ext),
    .inst_retire_i  (inst_retire),
    .interrupts_o   (interrupts),
    .mepc_o         (mepc),
    .mtvec_o        (mtvec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Combinational read of one CSR in the low clock phase.
  task automatic csr_read(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    @(negedge clk);
    csr_en   = 1'b1;
    csr_op   = 2'b00;
    csr_addr = addr;
    #1;
    check(tag, csr_rdata, exp);
    csr_en   = 1'b0;
  endtask

  // One CSR operation committed at the following rising edge.
  task automatic csr_do(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] data);
    @(negedge clk);
    csr_en    = 1'b1;
    csr_op    = op;
    csr_addr  = addr;
    csr_wdata = data;
    @(posedge clk);
    #1;
    csr_en    = 1'b0;
  endtask

  task automatic do_trap(input logic mret, input logic [31:0] epc,
                         input logic [31:0] cause, input logic [31:0] val);
    @(negedge clk);
    trap_insert  = 1'b1;
    trap_is_mret = mret;
    trap_epc     = epc;
    trap_cause   = cause;
    trap_val     = val;
    @(posedge clk);
    #1;
    trap_insert  = 1'b0;
    trap_is_mret = 1'b0;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    csr_en       = 1'b0;
    csr_op       = 2'b00;
    csr_addr     = 12'h000;
    csr_wdata    = 32'h0;
    trap_insert  = 1'b0;
    trap_is_mret = 1'b0;
    trap_epc     = 32'h0;
    trap_cause   = 32'h0;
    trap_val     = 32'h0;
    irq_soft     = 1'b0;
    irq_timer    = 1'b0;
    irq_ext      = 1'b0;
    inst_retire  = 1'b0;

    repeat (3) @(posedge clk);

    // Reset values, read while reset is held so the counters stay at zero.
    csr_read("rst_mstatus",   12'h300, 32'h0000_1800);
    csr_read("rst_misa",      12'h301, 32'h4000_0100);
    csr_read("rst_mie",       12'h304, 32'h0);
    csr_read("rst_mtvec",     12'h305, 32'h0);
    csr_read("rst_mscratch",  12'h340, 32'h0);
    csr_read("rst_mepc",      12'h341, 32'h0);
    csr_read("rst_mcause",    12'h342, 32'h0);
    csr_read("rst_mtval",     12'h343, 32'h0);
    csr_read("rst_mip",       12'h344, 32'h0);
    csr_read("rst_mcycle",    12'hB00, 32'h0);
    csr_read("rst_mcycleh",   12'hB80, 32'h0);
    csr_read("rst_minstret",  12'hB02, 32'h0);
    csr_read("rst_minstreth", 12'hB82, 32'h0);
    csr_read("rst_mhartid",   12'hF14, 32'(HART));
    check("rst_interrupts", interrupts, 32'h0);
    check("rst_mepc_o",     mepc,       32'h0);
    check("rst_mtvec_o",    mtvec,      32'h0);

    @(negedge clk);
    rst_n = 1'b1;

    // Interrupt enable path
    csr_do(2'b10, 12'h300, 32'h0000_0008);
    csr_read("mstatus_mie_set", 12'h300, 32'h0000_1808);
    csr_do(2'b01, 12'h304, 32'hFFFF_FFFF);
    csr_read("mie_warl", 12'h304, 32'h0000_0888);
    csr_do(2'b01, 12'h304, 32'h0000_0888);
    @(negedge clk);
    irq_timer = 1'b1;
    #1;
    check("irq_latency_0", interrupts, 32'h0);
    @(negedge clk);
    check("irq_timer_pend", interrupts, 32'h0000_0080);
    csr_read("mip_timer", 12'h344, 32'h0000_0080);
    csr_do(2'b01, 12'h344, 32'h0);  // ignored
    csr_read("mip_ro", 12'h344, 32'h0000_0080);
    csr_do(2'b11, 12'h300, 32'h0000_0008);
    #1;
    check("irq_mie_off", interrupts, 32'h0);
    @(negedge clk);
    irq_timer = 1'b0;

    // Trap entry and MRET
    csr_do(2'b10, 12'h300, 32'h0000_0008);
    do_trap(1'b0, 32'h0000_1002, 32'h8000_0007, 32'h0);
    check("trap_mepc_o", mepc, 32'h0000_1000);
    csr_read("trap_mcause",  12'h342, 32'h8000_0007);
    csr_read("trap_mtval",   12'h343, 32'h0);
    csr_read("trap_mstatus", 12'h300, 32'h0000_1880);
    do_trap(1'b1, 32'h0000_5554, 32'h1, 32'h2);
    csr_read("mret_mstatus", 12'h300, 32'h0000_1888);
    csr_read("mret_mcause",  12'h342, 32'h8000_0007);
    check("mret_mepc_o", mepc, 32'h0000_1000);

    // Trap and CSR write in the same cycle: trap wins
    @(negedge clk);
    csr_en       = 1'b1;
    csr_op       = 2'b01;
    csr_addr     = 12'h340;
    csr_wdata    = 32'h0000_DEAD;
    trap_insert  = 1'b1;
    trap_is_mret = 1'b0;
    trap_epc     = 32'h0000_2007;
    trap_cause   = 32'h0000_0002;
    trap_val     = 32'h0000_0055;
    @(posedge clk);
    #1;
    csr_en      = 1'b0;
    trap_insert = 1'b0;
    csr_read("coll_mscratch", 12'h340, 32'h0);
    check("coll_mepc_o", mepc, 32'h0000_2004);
    csr_read("coll_mcause",  12'h342, 32'h0000_0002);
    csr_read("coll_mtval",   12'h343, 32'h0000_0055);
    csr_read("coll_mstatus", 12'h300, 32'h0000_1880);

    // Plain writes and WARL fields
    csr_do(2'b01, 12'h340, 32'h0000_DEAD);
    csr_read("mscratch_wr", 12'h340, 32'h0000_DEAD);
    csr_do(2'b01, 12'h341, 32'h0000_1237);
    check("mepc_warl", mepc, 32'h0000_1234);
    csr_do(2'b01, 12'h301, 32'h1234_5678);
    csr_read("misa_ro", 12'h301, 32'h4000_0100);
    csr_do(2'b01, 12'h305, 32'h0000_0101);
    check("mtvec_vec", mtvec, 32'h0000_0101);
    csr_do(2'b01, 12'h305, 32'h0000_2003);
    check("mtvec_mode_keep", mtvec, 32'h0000_2001);
    csr_do(2'b11, 12'h305, 32'h0000_0001);
    check("mtvec_clear", mtvec, 32'h0000_2000);

    // Illegal accesses
    @(negedge clk);
    csr_en    = 1'b1;
    csr_op    = 2'b01;
    csr_addr  = 12'hF14;
    csr_wdata = 32'h0000_0055;
    #1;
    check("mhartid_wr_ill", {31'b0, csr_illegal}, 32'h1);
    csr_op = 2'b00;
    #1;
    check("mhartid_rd_ok", {31'b0, csr_illegal}, 32'h0);
    csr_en    = 1'b0;
    csr_read("mhartid_val", 12'hF14, 32'(HART));
    @(negedge clk);
    csr_en   = 1'b1;
    csr_op   = 2'b01;
    csr_addr = 12'h7C0;
    #1;
    check("unimpl_ill",   {31'b0, csr_illegal}, 32'h1);
    check("unimpl_rdata", csr_rdata, 32'h0);
    csr_en = 1'b0;
    #1;
    check("ill_needs_en", {31'b0, csr_illegal}, 32'h0);
    csr_read("ill_no_change", 12'h340, 32'h0000_DEAD);

    // minstret: write suppresses the same-cycle increment
    @(negedge clk);
    inst_retire = 1'b1;
    csr_do(2'b01, 12'hB02, 32'h0000_0005);
    csr_read("minstret_wr",  12'hB02, 32'h0000_0005);
    csr_read("minstret_inc", 12'hB02, 32'h0000_0006);
    inst_retire = 1'b0;

    // mcycle carry from low to high half
    csr_do(2'b01, 12'hB00, 32'hFFFF_FFFF);
    csr_do(2'b01, 12'hB80, 32'h0);
    csr_read("mcycleh_pre",   12'hB80, 32'h0);
    csr_read("mcycle_carry",  12'hB00, 32'h0);
    csr_read("mcycleh_carry", 12'hB80, 32'h0000_0001);

    // mcycle wrap at 2^64-1
    csr_do(2'b01, 12'hB00, 32'hFFFF_FFFF);
    csr_do(2'b01, 12'hB80, 32'hFFFF_FFFF);
    csr_read("mcycle_max",    12'hB00, 32'hFFFF_FFFF);
    csr_read("mcycle_wrap",   12'hB00, 32'h0);
    csr_read("mcycleh_wrap",  12'hB80, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
